samp_rate_ctl: RTL

Sample-rate controller for the wave generator's `clk_tx` domain. It owns the prescale value driven to the sample-clock divider. New prescale requests from the command parser are range-checked and only applied on a sample boundary, so the divider never sees a mid-period change. It also schedules fixed-length sample bursts by counting divider enable pulses and gating them to the sample datapath.

---
 rtl/samp_rate_ctl_if.sv | 30 +++
 rtl/samp_rate_ctl.sv | 110 +++++++++++
 2 files changed

// File: rtl/samp_rate_ctl_if.sv
// Purpose: groups the prescale-request, sample-boundary and burst-control signals
//          of the sample-rate controller into one bundle. The slave modport is the
//          controller; the master modport is the command parser / divider side.
// Ports:   pre_req/pre_req_val -> pre_ack/pre_err; en_clk_samp -> pre_clk_tx/pre_pend;
//          burst_start/burst_len/burst_stop -> burst_busy/burst_done/samp_gate.
interface samp_rate_ctl_if;
    logic        pre_req;
    logic [15:0] pre_req_val;
    logic        pre_ack;
    logic        pre_err;
    logic        en_clk_samp;
    logic [15:0] pre_clk_tx;
    logic        pre_pend;
    logic        burst_start;
    logic [15:0] burst_len;
    logic        burst_stop;
    logic        burst_busy;
    logic        burst_done;
    logic        samp_gate;

    modport slave (
        input  pre_req, pre_req_val, en_clk_samp, burst_start, burst_len, burst_stop,
        output pre_ack, pre_err, pre_clk_tx, pre_pend, burst_busy, burst_done, samp_gate
    );

    modport master (
        output pre_req, pre_req_val, en_clk_samp, burst_start, burst_len, burst_stop,
        input  pre_ack, pre_err, pre_clk_tx, pre_pend, burst_busy, burst_done, samp_gate
    );
endinterface

// File: rtl/samp_rate_ctl.sv
// Purpose: owns the divider prescale (range-checked requests, applied only on a
//          sample boundary) and schedules fixed-length sample bursts.
// Latency: ack/err/done one cycle after the causing input; samp_gate combinational.
// Backpressure: none; requests are always answered, latest pending value wins.
// Ports:   clk_tx, rst_clk_tx (sync, active-high), bus (samp_rate_ctl_if.slave).
module samp_rate_ctl #(
    parameter int PRE_MIN   = 32,
    parameter int PRE_RESET = 32
) (
    input  logic               clk_tx,
    input  logic               rst_clk_tx,
    samp_rate_ctl_if.slave     bus
);

    localparam logic [15:0] PRE_MIN_V   = 16'(PRE_MIN);
    localparam logic [15:0] PRE_RESET_V = 16'(PRE_RESET);

    typedef enum logic {IDLE, PEND} pre_state_t;

    pre_state_t  state_q, state_d;
    logic [15:0] pend_val_q, pend_val_d;
    logic [15:0] pre_q, pre_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic [15:0] rem_q, rem_d;
    logic        done_q, done_d;

    always_ff @(posedge clk_tx) begin
        if (rst_clk_tx) begin
            state_q    <= IDLE;
            pend_val_q <= '0;
            pre_q      <= PRE_RESET_V;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            rem_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_val_q <= pend_val_d;
            pre_q      <= pre_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
        end
    end

    // Prescale update. A request in a boundary cycle suppresses the apply, so the
    // freshly captured value always waits for the next boundary.
    always_comb begin
        state_d    = state_q;
        pend_val_d = pend_val_q;
        pre_d      = pre_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        if (bus.pre_req) begin
            if (bus.pre_req_val < PRE_MIN_V) begin
                err_d = 1'b1;
            end else begin
                pend_val_d = bus.pre_req_val;
                ack_d      = 1'b1;
                state_d    = PEND;
            end
        end else if (state_q == PEND && bus.en_clk_samp) begin
            pre_d   = pend_val_q;
            state_d = IDLE;
        end
    end

    // Burst scheduler. Stop wins over counting and start; start is ignored while busy.
    always_comb begin
        busy_d = busy_q;
        rem_d  = rem_q;
        done_d = 1'b0;
        if (bus.burst_stop) begin
            busy_d = 1'b0;
            rem_d  = '0;
        end else if (busy_q) begin
            if (bus.en_clk_samp) begin
                if (rem_q <= 16'd1) begin
                    busy_d = 1'b0;
                    rem_d  = '0;
                    done_d = 1'b1;
                end else begin
                    rem_d = rem_q - 16'd1;
                end
            end
        end else if (bus.burst_start) begin
            if (bus.burst_len != 16'd0) begin
                rem_d  = bus.burst_len;
                busy_d = 1'b1;
            end else begin
                done_d = 1'b1;
            end
        end
    end

    assign bus.pre_ack    = ack_q;
    assign bus.pre_err    = err_q;
    assign bus.pre_clk_tx = pre_q;
    assign bus.pre_pend   = (state_q == PEND);
    assign bus.burst_busy = busy_q;
    assign bus.burst_done = done_q;
    // Uses the registered busy so the start cycle is never gated and the stop cycle is.
    assign bus.samp_gate  = bus.en_clk_samp & busy_q;

endmodule
